// File: rtl/jk_cmd_seq_if.sv
// Command push channel into jk_cmd_seq: valid/ready handshake carrying a {j,k} code and a cycle count.
interface jk_cmd_seq_if #(
  parameter int CNT_W = 8
);
  logic             i_cmd_valid;
  logic [1:0]       i_cmd;
  logic [CNT_W-1:0] i_cmd_len;
  logic             o_cmd_ready;

  modport master (
    output i_cmd_valid,
    output i_cmd,
    output i_cmd_len,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd,
    input  i_cmd_len,
    output o_cmd_ready
  );
endinterface

// File: rtl/jk_cmd_seq.sv
// Queues timed J/K commands in a small FIFO and plays each one out on o_j/o_k
// for its requested number of cycles, back-to-back when entries are waiting.
module jk_cmd_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  jk_cmd_seq_if.slave            cmd,
  output logic                   o_j,
  output logic                   o_k,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state_q, state_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             j_q, j_d;
  logic             k_q, k_d;

  logic [1:0]       mem_code_q [DEPTH];
  logic [CNT_W-1:0] mem_len_q  [DEPTH];

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             last;
  logic [1:0]       head_code;
  logic [CNT_W-1:0] head_len;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign push      = cmd.i_cmd_valid && !full;
  assign last      = (state_q == RUN) && (rem_q == CNT_W'(1));
  assign pop       = !empty && ((state_q == IDLE) || last);
  assign head_code = mem_code_q[rd_ptr_q[AW-1:0]];
  assign head_len  = mem_len_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rem_d    = rem_q;
    j_d      = j_q;
    k_d      = k_q;

    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);

    if (pop) begin
      // A zero-length entry is consumed without producing any drive cycle.
      if (head_len != '0) begin
        state_d = RUN;
        rem_d   = head_len;
        j_d     = head_code[1];
        k_d     = head_code[0];
      end else begin
        state_d = IDLE;
        rem_d   = '0;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end
    end else if (state_q == RUN) begin
      if (last) begin
        state_d = IDLE;
        rem_d   = '0;
        j_d     = 1'b0;
        k_d     = 1'b0;
      end else begin
        rem_d = rem_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rem_q    <= '0;
      j_q      <= 1'b0;
      k_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rem_q    <= rem_d;
      j_q      <= j_d;
      k_q      <= k_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_code_q[wr_ptr_q[AW-1:0]] <= cmd.i_cmd;
      mem_len_q[wr_ptr_q[AW-1:0]]  <= cmd.i_cmd_len;
    end
  end

  assign cmd.o_cmd_ready = !full;
  assign o_j             = j_q;
  assign o_k             = k_q;
  assign o_busy          = (state_q == RUN);
  assign o_done          = last;
  assign o_level         = wr_ptr_q - rd_ptr_q;
endmodule

// File: tb/tb_jk_cmd_seq.sv
// Randomized and directed bench for jk_cmd_seq against a queue-based timeline model.
module tb_jk_cmd_seq;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jk_cmd_seq_if #(.CNT_W(CNT_W)) cif ();

  logic          o_j, o_k, o_busy, o_done;
  logic [LW-1:0] o_level;

  jk_cmd_seq #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .cmd     (cif.slave),
    .o_j     (o_j),
    .o_k     (o_k),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_level (o_level)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: queue of pending commands plus the command currently playing
  // and how many of its cycles are still to be shown (including the present one).
  typedef struct {
    logic [1:0]  code;
    int unsigned len;
  } ent_t;

  ent_t        mq[$];
  logic [1:0]  m_code;
  int unsigned m_left;
  bit          m_take, m_acc;
  ent_t        m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_code = 2'b00;
      m_left = 0;
    end else begin
      m_take = (mq.size() > 0) && (m_left <= 1);
      m_acc  = (cif.i_cmd_valid === 1'b1) && (mq.size() < DEPTH);
      if (m_take) begin
        m_e    = mq.pop_front();
        m_code = m_e.code;
        m_left = m_e.len;
      end else if (m_left > 0) begin
        m_left = m_left - 1;
      end
      if (m_acc) begin
        m_e.code = cif.i_cmd;
        m_e.len  = cif.i_cmd_len;
        mq.push_back(m_e);
      end
    end
  end

  function automatic logic [LW+4:0] exp_vec();
    exp_vec = {(mq.size() < DEPTH), (m_left > 0) ? m_code : 2'b00,
               (m_left > 0), (m_left == 1), LW'(mq.size())};
  endfunction

  logic [LW+4:0] dut_vec;
  assign dut_vec = {cif.o_cmd_ready, o_j, o_k, o_busy, o_done, o_level};

  // Observed drive trace, recorded mid-cycle.
  logic [1:0] trace[$];
  int         done_cnt, done_pos, max_lvl;
  bit         rec_en, saw_full;

  always @(negedge clk) begin
    if (rec_en) begin
      if (o_busy) trace.push_back({o_j, o_k});
      if (o_done) begin
        done_cnt++;
        done_pos = trace.size();
      end
      if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
      if (!cif.o_cmd_ready) saw_full = 1'b1;
    end
  end

  task automatic rec_start();
    trace.delete();
    done_cnt = 0;
    done_pos = 0;
    max_lvl  = 0;
    saw_full = 1'b0;
    rec_en   = 1'b1;
  endtask

  task automatic push_cmd(input string nm, input logic [1:0] c, input int unsigned l);
    bit acc;
    acc = 1'b0;
    cif.i_cmd_valid = 1'b1;
    cif.i_cmd       = c;
    cif.i_cmd_len   = CNT_W'(l);
    for (int i = 0; i < 400; i++) begin
      acc = cif.o_cmd_ready;
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL %s push: {rdy,j,k,busy,done,lvl} got %b want %b", nm, dut_vec, exp_vec());
      end
      if (acc) break;
    end
    if (!acc) begin
      fails++;
      $display("FAIL %s push_timeout: accepted got 0 want 1", nm);
    end
    cif.i_cmd_valid = 1'b0;
  endtask

  task automatic idle_n(input string nm, input int n);
    cif.i_cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL %s idle: {rdy,j,k,busy,done,lvl} got %b want %b", nm, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cif.i_cmd_valid = 1'($urandom_range(0, 1));
      cif.i_cmd       = 2'($urandom);
      cif.i_cmd_len   = CNT_W'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if (dut_vec !== {1'b1, 4'b0000, LW'(0)}) begin
      fails++;
      $display("FAIL reset_held: got %b want %b", dut_vec, {1'b1, 4'b0000, LW'(0)});
    end
    cif.i_cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (dut_vec !== {1'b1, 4'b0000, LW'(0)}) begin
      fails++;
      $display("FAIL reset_release: got %b want %b", dut_vec, {1'b1, 4'b0000, LW'(0)});
    end
    idle_n("reset", 3);
  endtask

  task automatic test_single();
    rec_start();
    push_cmd("single", 2'b10, 3);
    idle_n("single", 6);
    rec_en = 1'b0;
    checks++;
    if (trace.size() != 3 || trace[0] !== 2'b10 || trace[1] !== 2'b10 || trace[2] !== 2'b10) begin
      fails++;
      $display("FAIL single_trace: got %0d cycles want 3 cycles of 10", trace.size());
    end
    checks++;
    if (done_cnt != 1 || done_pos != 3) begin
      fails++;
      $display("FAIL single_done: got %0d pulses at %0d want 1 at 3", done_cnt, done_pos);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_tr[7];
    exp_tr = '{2'b11, 2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
    rec_start();
    push_cmd("b2b", 2'b11, 2);
    push_cmd("b2b", 2'b01, 1);
    push_cmd("b2b", 2'b10, 4);
    idle_n("b2b", 10);
    rec_en = 1'b0;
    checks++;
    if (trace.size() != 7) begin
      fails++;
      $display("FAIL b2b_len: got %0d want 7", trace.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (trace[i] !== exp_tr[i]) begin
          fails++;
          $display("FAIL b2b_seq[%0d]: got %b want %b", i, trace[i], exp_tr[i]);
        end
      end
    end
    checks++;
    if (done_cnt != 3) begin
      fails++;
      $display("FAIL b2b_done: got %0d want 3", done_cnt);
    end
  endtask

  task automatic test_zero_len();
    rec_start();
    push_cmd("zero", 2'b10, 2);
    push_cmd("zero", 2'b11, 0);
    push_cmd("zero", 2'b01, 1);
    idle_n("zero", 8);
    rec_en = 1'b0;
    checks++;
    if (trace.size() != 3 || trace[0] !== 2'b10 || trace[1] !== 2'b10 || trace[2] !== 2'b01) begin
      fails++;
      $display("FAIL zero_trace: got %0d busy cycles want 10,10,01", trace.size());
    end
    checks++;
    if (done_cnt != 2) begin
      fails++;
      $display("FAIL zero_done: got %0d want 2", done_cnt);
    end
  endtask

  task automatic test_full();
    logic [1:0] exp_tail[7];
    exp_tail = '{2'b01, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b10};
    rec_start();
    push_cmd("full", 2'b00, 200);
    push_cmd("full", 2'b01, 1);
    push_cmd("full", 2'b10, 2);
    push_cmd("full", 2'b11, 1);
    push_cmd("full", 2'b01, 2);
    push_cmd("full", 2'b10, 1);
    idle_n("full", 12);
    rec_en = 1'b0;
    checks++;
    if (max_lvl != DEPTH || !saw_full) begin
      fails++;
      $display("FAIL full_level: got max %0d notready %0d want %0d 1", max_lvl, saw_full, DEPTH);
    end
    checks++;
    if (trace.size() != 207 || done_cnt != 6) begin
      fails++;
      $display("FAIL full_count: got %0d cycles %0d dones want 207 6", trace.size(), done_cnt);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (trace[200+i] !== exp_tail[i]) begin
          fails++;
          $display("FAIL full_seq[%0d]: got %b want %b", i, trace[200+i], exp_tail[i]);
        end
      end
    end
  endtask

  task automatic test_count_wrap();
    int bad;
    rec_start();
    push_cmd("wrap", 2'b10, 255);
    idle_n("wrap", 262);
    rec_en = 1'b0;
    bad = 0;
    foreach (trace[i]) if (trace[i] !== 2'b10) bad++;
    checks++;
    if (trace.size() != 255 || bad != 0) begin
      fails++;
      $display("FAIL wrap_len: got %0d cycles (%0d wrong) want 255", trace.size(), bad);
    end
    checks++;
    if (done_cnt != 1 || done_pos != 255) begin
      fails++;
      $display("FAIL wrap_done: got %0d at %0d want 1 at 255", done_cnt, done_pos);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      cif.i_cmd_valid = 1'($urandom_range(0, 2) != 0);
      cif.i_cmd       = 2'($urandom);
      cif.i_cmd_len   = CNT_W'($urandom_range(0, 5));
      @(posedge clk); #1;
      checks++;
      if (dut_vec !== exp_vec()) begin
        fails++;
        $display("FAIL random[%0d]: {rdy,j,k,busy,done,lvl} got %b want %b", i, dut_vec, exp_vec());
      end
    end
    idle_n("random", 40);
  endtask

  task automatic test_reset_mid();
    push_cmd("rstmid", 2'b11, 50);
    push_cmd("rstmid", 2'b10, 5);
    idle_n("rstmid", 4);
    checks++;
    if (o_busy !== 1'b1 || o_level === LW'(0)) begin
      fails++;
      $display("FAIL rstmid_pre: busy %b level %0d want 1 nonzero", o_busy, o_level);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== {1'b1, 4'b0000, LW'(0)}) begin
      fails++;
      $display("FAIL rstmid_async: got %b want %b", dut_vec, {1'b1, 4'b0000, LW'(0)});
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_n("rstmid", 5);
  endtask

  initial begin
    rec_en          = 1'b0;
    cif.i_cmd_valid = 1'b0;
    cif.i_cmd       = 2'b00;
    cif.i_cmd_len   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_len();
    test_full();
    test_count_wrap();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/jk_cmd_seq.md
# jk_cmd_seq

Command sequencer that drives the J/K inputs of a downstream JK flip-flop stage. Upstream logic pushes commands (hold/reset/set/toggle plus a cycle count) through a valid/ready handshake into a small FIFO. The block plays each command out on o_j/o_k for the requested number of cycles, back-to-back when commands are queued.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥2
- CNT_W, 8: width of the per-command cycle count
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_valid  in  1  command present on i_cmd/i_cmd_len
- i_cmd  in  2  {j,k} code: 00 hold, 01 reset, 10 set, 11 toggle
- i_cmd_len  in  CNT_W  number of cycles to apply the command; 0 = discard
- o_cmd_ready  out  1  FIFO not full; command accepted on edge where valid&ready
- o_j  out  1  J drive to the flip-flop stage (registered)
- o_k  out  1  K drive to the flip-flop stage (registered)
- o_busy  out  1  FSM in RUN
- o_done  out  1  high during the final cycle of each nonzero-length command
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH

## Operation
- Reset (async, i_rst_n=0): FIFO emptied (pointers 0), FSM IDLE, remaining counter 0. Outputs: o_j=0, o_k=0, o_busy=0, o_done=0, o_level=0, o_cmd_ready=1 (after reset is released; also 1 during reset).
- FIFO: DEPTH×(2+CNT_W) entries, wrap-around pointers with one extra bit for full/empty. o_cmd_ready = !full, from current state only. A push while full is ignored even if a pop happens on the same edge. Simultaneous push and pop when not full: o_level unchanged.
- FSM states:
  - IDLE: o_j=o_k=0 (hold).
  - RUN: o_j/o_k = current command code; remaining counter counts down.
- Pop condition: (IDLE and FIFO non-empty) or (RUN and remaining==1 and FIFO non-empty).
- On pop, len≠0:
  - load code to o_j/o_k and remaining=len; state RUN.
- On pop, len==0:
  - entry discarded, no output cycles, no o_done; state IDLE, o_j=o_k=0.
- RUN, remaining>1: remaining decrements; o_j/o_k held.
- RUN, remaining==1 and no pop: state IDLE, o_j=o_k=0 on that edge.
- o_done = RUN && remaining==1 (combinational from registers, aligned with the last command cycle).
- Command code 00 with len>0 is a valid timed hold: o_busy=1, outputs 0/0 for len cycles.
- Reset asserted mid-command: command aborted immediately, queued commands lost, outputs return to reset values asynchronously.

## Timing
- Push-to-drive latency, idle and empty FIFO: a command accepted on edge N is written to the FIFO at N, popped at N+1, and drives o_j/o_k for cycles N+1 .. N+len (len cycles after edge N+1).
- Back-to-back: when the next queued entry has len≠0, it starts on the edge that ends the previous command's final cycle, with no gap cycle.
- o_level updates on the push/pop edge. o_cmd_ready deasserts in the cycle after the push that fills the FIFO.
- Maximum per-command duration: 2^CNT_W−1 cycles.

## Test plan
- Reset: hold i_rst_n=0 with random inputs, then release -> o_j=o_k=0, o_busy=0, o_done=0, o_level=0, o_cmd_ready=1; assert reset mid-command -> outputs clear with no clock edge.
- Single command: push {10,len=3} at edge N, idle -> o_j=1,o_k=0 for exactly 3 cycles starting after N+1; o_done high in cycle 3 only; then 0/0 and o_busy=0.
- Back-to-back: push {11,2},{01,1},{10,4} consecutively -> contiguous output sequence 11,11,01,10,10,10,10 with no gaps; three o_done pulses.
- Zero length: push {10,2},{11,0},{01,1} -> 10,10, then one idle 00 cycle, then 01 for one cycle; no o_done for the len=0 entry.
- Full FIFO (DEPTH=4): push {00,200} then 5 more commands with valid held -> o_level reaches 4, o_cmd_ready=0, 6th command accepted only after the first pop; no entry overwritten or dropped.
- Count wrap: len=255 (CNT_W=8) -> exactly 255 cycles of drive, o_done on the 255th cycle.
